fetch_pc_gen: RTL and testbench

Fetch-stage next-PC generator that sits directly upstream of the local branch predictor. It produces `pcF`, which indexes the predictor's BHT/PHT, and consumes the predictor's `pred_takeD` and `correct` outputs. It redirects fetch to the branch target on a decode-stage taken prediction. It carries the not-chosen ("alternate") PC down to M and restores it on a misprediction. It also keeps saturating branch and misprediction statistics counters.

---
 rtl/fetch_pc_gen.sv | 105 ++++++++++
 tb/tb_fetch_pc_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator with D-stage redirect, alternate-PC
// pipeline for misprediction recovery, and saturating branch statistics.
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallF,
    input  logic             stallD,
    input  logic             flushD,
    input  logic             flushE,
    input  logic             flushM,
    input  logic [31:0]      pcD,
    input  logic             branchD,
    input  logic             pred_takeD,
    input  logic [31:0]      branch_targetD,
    input  logic             branchM,
    input  logic             correct,
    output logic [31:0]      pcF,
    output logic             redirectD,
    output logic             recoverM,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic        validD;
    logic [31:0] altD;
    logic        validE;
    logic [31:0] altE;
    logic        validM;
    logic [31:0] altM;
    logic [31:0] pcNext;
    logic        brResolved;

    assign validD    = branchD & ~stallD & ~flushD;
    assign redirectD = validD & pred_takeD;
    assign altD      = pred_takeD ? (pcD + 32'd4) : branch_targetD;

    assign recoverM   = validM & branchM & ~correct;
    assign brResolved = validM & branchM;

    // Recovery outranks stallF: the stalled fetch is on the wrong path.
    always_comb begin
        pcNext = pcF + 32'd4;
        if (recoverM) begin
            pcNext = {altM[31:2], 2'b00};
        end else if (stallF) begin
            pcNext = pcF;
        end else if (redirectD) begin
            pcNext = {branch_targetD[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcF <= {RESET_PC[31:2], 2'b00};
        end else begin
            pcF <= pcNext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validE <= 1'b0;
            altE   <= 32'd0;
        end else if (flushE) begin
            validE <= 1'b0;
            altE   <= 32'd0;
        end else begin
            validE <= validD;
            altE   <= altD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validM <= 1'b0;
            altM   <= 32'd0;
        end else if (flushM) begin
            validM <= 1'b0;
            altM   <= 32'd0;
        end else begin
            validM <= validE;
            altM   <= altE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (brResolved && branch_cnt != CNT_MAX) begin
                branch_cnt <= branch_cnt + 1'b1;
            end
            if (recoverM && mispred_cnt != CNT_MAX) begin
                mispred_cnt <= mispred_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Scoreboard bench for fetch_pc_gen: stimulus queues expected values per
// cycle, a negedge monitor pops and compares them.
module tb_fetch_pc_gen;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stallF = 1'b0;
    logic          stallD = 1'b0;
    logic          flushD = 1'b0;
    logic          flushE = 1'b0;
    logic          flushM = 1'b0;
    logic [31:0]   pcD = 32'd0;
    logic          branchD = 1'b0;
    logic          pred_takeD = 1'b0;
    logic [31:0]   branch_targetD = 32'd0;
    logic          branchM = 1'b0;
    logic          correct = 1'b0;
    logic [31:0]   pcF;
    logic          redirectD;
    logic          recoverM;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] mispred_cnt;

    fetch_pc_gen #(.RESET_PC(32'hBFC0_0000), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .pcD(pcD),
        .branchD(branchD), .pred_takeD(pred_takeD),
        .branch_targetD(branch_targetD), .branchM(branchM),
        .correct(correct), .pcF(pcF), .redirectD(redirectD),
        .recoverM(recoverM), .branch_cnt(branch_cnt),
        .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    localparam int K_PC  = 0;
    localparam int K_RED = 1;
    localparam int K_REC = 2;
    localparam int K_BR  = 3;
    localparam int K_MIS = 4;

    typedef struct {
        int          cyc;
        string       name;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   nTests = 0;
    int   nFail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic want(input string nm, input int kind, input logic [31:0] v);
        q.push_back('{cyc, nm, kind, v});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] actual(input int kind);
        logic [31:0] a;
        a = 32'd0;
        case (kind)
            K_PC:    a = pcF;
            K_RED:   a = {31'd0, redirectD};
            K_REC:   a = {31'd0, recoverM};
            K_BR:    a = {{(32-CW){1'b0}}, branch_cnt};
            default: a = {{(32-CW){1'b0}}, mispred_cnt};
        endcase
        return a;
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] a;
            e = q.pop_front();
            a = actual(e.kind);
            nTests++;
            if (e.cyc != cyc) begin
                nFail++;
                $display("FAIL %s: stale expectation cyc %0d at %0d", e.name, e.cyc, cyc);
            end else if (a !== e.val) begin
                nFail++;
                $display("FAIL %s: got %h want %h", e.name, a, e.val);
            end
        end
    end

    initial begin
        int mis;
        int br;
        tick();
        tick();
        want("rst_pc", K_PC, 32'hBFC0_0000);
        want("rst_br", K_BR, 0);
        want("rst_mis", K_MIS, 0);
        want("rst_rec", K_REC, 0);
        rst = 1'b1;
        tick(); want("seq1", K_PC, 32'hBFC0_0004);
        tick(); want("seq2", K_PC, 32'hBFC0_0008);

        // predicted taken, correct
        tick();
        pcD = 32'h100; branchD = 1; pred_takeD = 1; branch_targetD = 32'h200;
        want("tk_red", K_RED, 1);
        want("tk_pc0", K_PC, 32'hBFC0_000C);
        tick(); branchD = 0;
        want("tk_pc1", K_PC, 32'h200);
        want("tk_red0", K_RED, 0);
        tick(); branchM = 1; correct = 1;
        want("tk_rec", K_REC, 0);
        want("tk_pc2", K_PC, 32'h204);
        tick(); branchM = 0;
        want("tk_br", K_BR, 1);
        want("tk_mis", K_MIS, 0);
        want("tk_pc3", K_PC, 32'h208);

        // predicted taken, wrong
        tick(); branchD = 1;
        want("tw_red", K_RED, 1);
        want("tw_pc0", K_PC, 32'h20C);
        tick(); branchD = 0;
        want("tw_pc1", K_PC, 32'h200);
        tick(); branchM = 1; correct = 0;
        want("tw_rec", K_REC, 1);
        tick(); branchM = 0;
        want("tw_pc", K_PC, 32'h104);
        want("tw_mis", K_MIS, 1);
        want("tw_br", K_BR, 2);

        // predicted not-taken, wrong, recovery overrides stallF
        tick();
        pcD = 32'h108; branchD = 1; pred_takeD = 0; branch_targetD = 32'h300;
        want("nt_red", K_RED, 0);
        want("nt_pc0", K_PC, 32'h108);
        tick(); branchD = 0;
        want("nt_pc1", K_PC, 32'h10C);
        tick(); branchM = 1; correct = 0; stallF = 1;
        want("nt_rec", K_REC, 1);
        tick(); branchM = 0; stallF = 0;
        want("nt_pc", K_PC, 32'h300);
        want("nt_br", K_BR, 3);
        want("nt_mis", K_MIS, 2);

        // flushE kills the branch as it moves into E
        tick();
        pcD = 32'h300; branchD = 1; branch_targetD = 32'h400; flushE = 1;
        want("fe_pc0", K_PC, 32'h304);
        tick(); branchD = 0; flushE = 0;
        tick(); branchM = 1; correct = 0;
        want("fe_rec", K_REC, 0);
        want("fe_pc", K_PC, 32'h30C);
        tick(); branchM = 0;
        want("fe_br", K_BR, 3);
        want("fe_mis", K_MIS, 2);
        want("fe_pc1", K_PC, 32'h310);

        // flushM with a valid E entry
        tick();
        pcD = 32'h310; branchD = 1; branch_targetD = 32'h500;
        tick(); branchD = 0; flushM = 1;
        tick(); flushM = 0; branchM = 1; correct = 0;
        want("fm_rec", K_REC, 0);
        tick(); branchM = 0;
        want("fm_pc", K_PC, 32'h320);
        want("fm_mis", K_MIS, 2);

        // stallD suppresses redirect; stallF holds pcF
        tick();
        pcD = 32'h320; branchD = 1; pred_takeD = 1;
        branch_targetD = 32'h600; stallD = 1;
        want("sd_red", K_RED, 0);
        tick(); branchD = 0; stallD = 0; pred_takeD = 0; stallF = 1;
        want("sf_pc0", K_PC, 32'h328);
        tick(); stallF = 0;
        want("sf_pc1", K_PC, 32'h328);
        tick();
        want("sf_pc2", K_PC, 32'h32C);

        // unaligned target is forced to word alignment
        tick();
        pcD = 32'h32C; branchD = 1; pred_takeD = 1; branch_targetD = 32'h6A7;
        tick(); branchD = 0; pred_takeD = 0;
        want("al_pc", K_PC, 32'h6A4);
        tick(); tick();

        // saturation
        mis = 2; br = 3;
        for (int i = 0; i < 6; i++) begin
            tick();
            pcD = 32'h0; branchD = 1; branch_targetD = 32'h700;
            tick(); branchD = 0;
            tick(); branchM = 1; correct = 0;
            want("sat_rec", K_REC, 1);
            tick(); branchM = 0;
            mis = (mis + 1 > 7) ? 7 : mis + 1;
            br = (br + 1 > 7) ? 7 : br + 1;
            want("sat_mis", K_MIS, mis);
            want("sat_br", K_BR, br);
        end
        want("sat_pc", K_PC, 32'h700);

        // asynchronous reset mid-cycle
        tick();
        want("pre_rst_pc", K_PC, 32'h704);
        @(negedge clk);
        #2;
        rst = 0; branchD = 1; pred_takeD = 1; branchM = 1; correct = 0;
        #1;
        nTests++;
        if (pcF !== 32'hBFC0_0000 || branch_cnt !== 0 || mispred_cnt !== 0) begin
            nFail++;
            $display("FAIL arst_now: pcF %h br %0d mis %0d", pcF, branch_cnt, mispred_cnt);
        end
        tick();
        want("arst_pc", K_PC, 32'hBFC0_0000);
        want("arst_br", K_BR, 0);
        want("arst_mis", K_MIS, 0);
        want("arst_rec", K_REC, 0);
        want("arst_red", K_RED, 1);
        tick();
        branchD = 0; pred_takeD = 0; branchM = 0;
        tick();
        @(negedge clk);
        #1;
        nTests++;
        if (q.size() != 0) begin
            nFail++;
            $display("FAIL drain: %0d left want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
